// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multicycle main control unit: opcode map, ALUOp codes
// (also consumed by the ALU control decoder), datapath select encodings, state encoding
// and the bundle of control outputs.
package main_control_fsm_pkg;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_RT_LO = 4'b0010;
    localparam logic [3:0] OP_RT_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;

    // ALUOp handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b10;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b00;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_MEM_TMO = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_RTYPE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    // All control outputs except the sticky fault code
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        if (op == OP_LW || op == OP_SW) begin
            cls = CLS_MEM;
        end else if (op >= OP_RT_LO && op <= OP_RT_HI) begin
            cls = CLS_RTYPE;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            cls = CLS_BRANCH;
        end else if (op == OP_JMP) begin
            cls = CLS_JUMP;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath/memory (slave).
interface main_control_fsm_if #(
    parameter int unsigned OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_source;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                halted;
    logic [1:0]          fault;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, halted, fault
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, halted, fault
    );
endinterface

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Wait-state counter for memory accesses. Counts cycles spent in a memory state without
// mem_ready and flags a timeout when the count sits at MEM_TIMEOUT and ready is still low.
module main_control_fsm_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);
    localparam logic [TMO_W-1:0] Limit = TMO_W'(MEM_TIMEOUT);

    logic [TMO_W-1:0] count_q, count_d;
    logic             waiting;

    assign waiting = active_i && !ready_i;

    // Count while waiting; any completion or non-memory state clears it, which gives a
    // fresh count on every entry into a memory state.
    always_comb begin
        count_d = '0;
        if (waiting) begin
            count_d = (count_q == Limit) ? count_q : count_q + TMO_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Ready arriving at the limit still completes the access
    assign timeout_o = waiting && (count_q == Limit);

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control unit for the 16-bit datapath. Sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and select plus ALUOp.
// Build option: define ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with fault 10;
// otherwise illegal opcodes execute as NOPs.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input logic                clk,
    input logic                rst,
    main_control_fsm_if.master bus_io
);

    state_t              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    ctrl_t               ctrl;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_active;
    logic                timeout;

    assign opcode     = bus_io.opcode;
    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    main_control_fsm_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMO_W      (TMO_W)
    ) u_mem_wait_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .active_i (mem_active),
        .ready_i  (bus_io.mem_ready),
        .timeout_o(timeout)
    );

    // Next-state and Moore output decode; only FETCH's IR/PC writes look at mem_ready
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ctrl    = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (bus_io.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_MEM_TMO;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target
                ctrl.alu_src_b = SRCB_SHIFT;
                ctrl.alu_op    = ALUOP_ADD;
                unique case (op_class(opcode))
                    CLS_MEM:    state_d = S_MEMADR;
                    CLS_RTYPE:  state_d = S_EXEC;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus_io.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_MEM_TMO;
                end
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus_io.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_MEM_TMO;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNC;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Reset is asynchronous to the outputs too, so an in-flight request drops at once
        if (rst) begin
            ctrl = '0;
        end
    end

    // State and sticky fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign bus_io.mem_req       = ctrl.mem_req;
    assign bus_io.mem_read      = ctrl.mem_read;
    assign bus_io.mem_write     = ctrl.mem_write;
    assign bus_io.i_or_d        = ctrl.i_or_d;
    assign bus_io.ir_write      = ctrl.ir_write;
    assign bus_io.pc_write      = ctrl.pc_write;
    assign bus_io.pc_write_cond = ctrl.pc_write_cond;
    assign bus_io.branch_ne     = ctrl.branch_ne;
    assign bus_io.pc_source     = ctrl.pc_source;
    assign bus_io.alu_src_a     = ctrl.alu_src_a;
    assign bus_io.alu_src_b     = ctrl.alu_src_b;
    assign bus_io.alu_op        = ctrl.alu_op;
    assign bus_io.reg_write     = ctrl.reg_write;
    assign bus_io.reg_dst       = ctrl.reg_dst;
    assign bus_io.mem_to_reg    = ctrl.mem_to_reg;
    assign bus_io.halted        = ctrl.halted;
    assign bus_io.fault         = fault_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: each instruction is expanded into a list of expected cycles
// (instruction class plus memory wait plan) and replayed cycle by cycle against the DUT.
module tb_main_control_fsm;

    localparam int TMO = 15;

    // Bench-local phase labels for the instruction expansion
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_MEMADR = 2;
    localparam int PH_MEMRD  = 3;
    localparam int PH_MEMWB  = 4;
    localparam int PH_MEMWR  = 5;
    localparam int PH_EXEC   = 6;
    localparam int PH_ALUWB  = 7;
    localparam int PH_BRANCH = 8;
    localparam int PH_JUMP   = 9;
    localparam int PH_HALT   = 10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
        logic [1:0] fault;
    } obs_t;

    typedef struct packed {
        logic [3:0] op;
        logic       rdy;
        obs_t       exp;
    } rec_t;

    rec_t       rec_q[$];
    string      tag_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] m_fault  = 2'b00;
    bit         m_halted = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    obs_t dut_obs;

    always #5 clk = ~clk;

    main_control_fsm_if #(.OPCODE_W(4)) bus ();

    main_control_fsm #(
        .OPCODE_W   (4),
        .MEM_TIMEOUT(TMO),
        .TMO_W      (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    assign dut_obs = {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                      bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.reg_dst,
                      bus.mem_to_reg, bus.halted, bus.fault};

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rndb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Output pattern each phase is specified to show
    function automatic obs_t ph_obs(input int ph, input logic rdy, input logic [3:0] op,
                                    input logic [1:0] flt);
        obs_t o;
        o = '0;
        o.fault = flt;
        case (ph)
            PH_FETCH: begin
                o.mem_req = 1'b1; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
                o.ir_write = rdy; o.pc_write = rdy;
            end
            PH_DECODE: begin
                o.alu_src_b = 2'b11; o.alu_op = 2'b10;
            end
            PH_MEMADR: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b10;
            end
            PH_MEMRD: begin
                o.mem_req = 1'b1; o.mem_read = 1'b1; o.i_or_d = 1'b1;
            end
            PH_MEMWB: begin
                o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
            end
            PH_MEMWR: begin
                o.mem_req = 1'b1; o.mem_write = 1'b1; o.i_or_d = 1'b1;
            end
            PH_EXEC: begin
                o.alu_src_a = 1'b1;
            end
            PH_ALUWB: begin
                o.reg_write = 1'b1; o.reg_dst = 1'b1;
            end
            PH_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                o.pc_source = 2'b01; o.branch_ne = (op == 4'b1100);
            end
            PH_JUMP: begin
                o.pc_write = 1'b1; o.pc_source = 2'b10;
            end
            PH_HALT: begin
                o.halted = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int ph, input logic rdy, input logic [3:0] op, input string tag);
        rec_t r;
        r.op  = op;
        r.rdy = rdy;
        r.exp = ph_obs(ph, rdy, op, m_fault);
        rec_q.push_back(r);
        tag_q.push_back(tag);
    endtask

    task automatic push_halt(input string tag);
        for (int i = 0; i < 3; i++) push(PH_HALT, rndb(), rnd4(), tag);
        m_halted = 1'b1;
    endtask

    // Memory phase whose ready arrives after w idle cycles; gives up at the timeout count
    task automatic push_mem(input int ph, input int w, input string tag, output bit to);
        to = 1'b0;
        for (int k = 0; k <= w; k++) begin
            push(ph, (k == w), rnd4(), $sformatf("%s.w%0d", tag, k));
            if (k != w && k == TMO) begin
                m_fault = 2'b01;
                to      = 1'b1;
                return;
            end
        end
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic plan_instr(input logic [3:0] op, input int wf, input int wm, input string nm);
        bit to;
        push_mem(PH_FETCH, wf, {nm, ".fetch"}, to);
        if (to) begin
            push_halt({nm, ".halt"});
            return;
        end
        push(PH_DECODE, rndb(), op, {nm, ".decode"});
        if (op <= 4'd1) begin
            push(PH_MEMADR, rndb(), op, {nm, ".memadr"});
            if (op == 4'd0) begin
                push_mem(PH_MEMRD, wm, {nm, ".memrd"}, to);
                if (to) begin
                    push_halt({nm, ".halt"});
                    return;
                end
                push(PH_MEMWB, rndb(), rnd4(), {nm, ".memwb"});
            end else begin
                push_mem(PH_MEMWR, wm, {nm, ".memwr"}, to);
                if (to) push_halt({nm, ".halt"});
            end
        end else if (op >= 4'd2 && op <= 4'd9) begin
            push(PH_EXEC, rndb(), rnd4(), {nm, ".exec"});
            push(PH_ALUWB, rndb(), rnd4(), {nm, ".aluwb"});
        end else if (op == 4'd11 || op == 4'd12) begin
            push(PH_BRANCH, rndb(), op, {nm, ".branch"});
        end else if (op == 4'd13) begin
            push(PH_JUMP, rndb(), rnd4(), {nm, ".jump"});
        end else begin
`ifdef ILLEGAL_TRAP_EN
            m_fault = 2'b10;
            push_halt({nm, ".trap"});
`endif
        end
    endtask

    // Replay up to n planned cycles; entered and left at posedge+1
    task automatic drain(input int n);
        rec_t  r;
        string t;
        int    k;
        k = 0;
        while (rec_q.size() > 0 && k < n) begin
            r = rec_q.pop_front();
            t = tag_q.pop_front();
            bus.opcode    = r.op;
            bus.mem_ready = r.rdy;
            @(negedge clk);
            check(t, dut_obs, r.exp);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Assert reset mid-cycle, check outputs drop at once, release at posedge+1
    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check(tag, dut_obs, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_fault  = 2'b00;
        m_halted = 1'b0;
        rec_q.delete();
        tag_q.delete();
    endtask

    initial begin
        logic [3:0] op;
        int         wf;
        int         wm;

        bus.opcode    = 4'd0;
        bus.mem_ready = 1'b0;
        do_reset("reset_init");

        plan_instr(4'b0010, 0, 0, "rtype");
        drain(1000);
        plan_instr(4'b0000, 0, 3, "lw_wait3");
        drain(1000);
        plan_instr(4'b1100, 0, 0, "bne");
        drain(1000);
        plan_instr(4'b1011, 2, 0, "beq");
        drain(1000);
        plan_instr(4'b1101, 0, 0, "jmp");
        drain(1000);
        plan_instr(4'b0001, 1, 2, "sw");
        drain(1000);

        plan_instr(4'b0010, 20, 0, "fetch_tmo");
        drain(1000);
        do_reset("reset_after_tmo");
        plan_instr(4'b0010, TMO, 0, "fetch_edge");
        drain(1000);
        plan_instr(4'b0000, 0, 30, "memrd_tmo");
        drain(1000);
        do_reset("reset_after_memrd_tmo");

        plan_instr(4'b1111, 0, 0, "illegal");
        drain(1000);
        if (m_halted) do_reset("reset_after_trap");
        plan_instr(4'b1010, 0, 0, "illegal_a");
        drain(1000);
        if (m_halted) do_reset("reset_after_trap_a");

        // Abort a store mid-wait with reset
        plan_instr(4'b0001, 0, 30, "sw_rst");
        drain(4);
        bus.mem_ready = 1'b0;
        #1;
        check("sw_rst.mid_wait", dut_obs, ph_obs(PH_MEMWR, 1'b0, 4'd0, 2'b00));
        do_reset("sw_rst.drop");
        plan_instr(4'b0010, 0, 0, "after_rst");
        drain(1000);

        for (int i = 0; i < 80; i++) begin
            op = rnd4();
            wf = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 3));
            plan_instr(op, wf, wm, $sformatf("rnd%0d_op%0d", i, op));
            drain(1000);
            if (m_halted) do_reset($sformatf("rnd%0d.reset", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle main control unit for the 16-bit datapath.
- Decodes the 4-bit instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives every datapath enable and mux select, plus the 2-bit ALUOp consumed directly by the downstream ALU control decoder.
- Handles a ready-based memory handshake with a wait-state timeout.

Parameters:
- OPCODE_W, 4, instruction opcode width (must match the ALU control decoder input).
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before faulting (1..255).
- TMO_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  OPCODE_W  IR[15:12], valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access in progress.
- mem_read  out  1  read request (FETCH, MEMRD).
- mem_write  out  1  write request (MEMWR).
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if the branch condition holds.
- branch_ne  out  1  1 = condition is !zero, 0 = zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 shifted imm.
- alu_op  out  2  10 add, 01 subtract, 00 function from opcode.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- halted  out  1  FSM parked in HALT.
- fault  out  2  00 none, 01 memory timeout, 10 illegal opcode.

Behaviour:
- Moore FSM; all outputs decode from the registered state only, except ir_write/pc_write in FETCH, which are qualified by mem_ready.
- On rst, asynchronously:
  - state = FETCH, wait counter = 0, fault = 00.
  - All enable outputs are 0; selects and alu_op are 00.
- Opcode map:
  - 0000 LW
  - 0001 SW
  - 0010–1001 R-type
  - 1011 BEQ
  - 1100 BNE
  - 1101 JMP
  - 1010, 1110, 1111 illegal
- States and transitions:
  - FETCH: mem_req=mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=10. When mem_ready: ir_write=pc_write=1 and go to DECODE; otherwise stay.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=10 (branch target). Next state by opcode: LW/SW→MEMADR; R-type→EXEC; BEQ/BNE→BRANCH; JMP→JUMP; illegal→see Optional Feature.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=10. LW→MEMRD, SW→MEMWR.
  - MEMRD: mem_req=mem_read=1, i_or_d=1. When mem_ready go to MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
  - MEMWR: mem_req=mem_write=1, i_or_d=1. When mem_ready go to FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=00, then ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==1100), then FETCH.
  - JUMP: pc_write=1, pc_source=10, then FETCH.
  - HALT: all enables 0, halted=1. Exit only via rst.
- Latencies (cycles):
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE: 3
  - JMP: 3
  - Each memory state adds N wait cycles when mem_ready arrives N cycles late.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: next state HALT, fault=01.
  - If mem_ready arrives in the same cycle the count reaches MEM_TIMEOUT, the access completes and there is no fault.
- Opcode is sampled only in DECODE, MEMADR, and BRANCH; changes elsewhere are ignored.
- rst asserted mid-access drops mem_req in the same cycle (asynchronous). A memory response arriving after reset is ignored because FETCH starts fresh.
- fault is sticky until rst.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT with fault=10.
- Undefined: an illegal opcode is a NOP; DECODE goes to FETCH and fault stays 00. Fault value 10 is never produced.

Decomposition:
- Shared package/header ctrl_defs holds:
  - Opcode constants OP_LW..OP_JMP.
  - ALUOp constants ALUOP_ADD=10, ALUOP_SUB=01, ALUOP_FUNC=00 (shared with the ALU control decoder).
  - State encoding S_FETCH..S_HALT (4-bit).
  - pc_source and alu_src_b encodings.
- One sub-module: mem_wait_timer (counter + timeout compare), instantiated once.

Test Plan:
- Reset then R-type opcode 0010 with mem_ready always 1 → states FETCH, DECODE, EXEC, ALUWB; alu_op sequence 10, 10, 00, 00; reg_write=1 and reg_dst=1 only in cycle 4.
- LW opcode 0000 with mem_ready delayed 3 cycles in MEMRD → MEMRD lasts 4 cycles; mem_to_reg=1 and reg_write=1 in MEMWB; total 8 cycles.
- BNE opcode 1100 → BRANCH asserts pc_write_cond=1, branch_ne=1, alu_op=01, pc_source=01; back in FETCH on the next cycle.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → HALT after 15 wait cycles, fault=01, halted=1. Repeat with mem_ready=1 exactly at count 15 → no fault, goes to DECODE.
- Opcode 1111 → with ILLEGAL_TRAP_EN: HALT, fault=10. Without: FETCH on the next cycle, fault=00.
- rst pulsed during MEMWR wait → mem_req and mem_write drop immediately; state FETCH after rst falls; fault=00.
